apb_bridge_nslv: RTL

Parametrised APB master bridge. Converts a simple valid/ready command interface into APB3 transfers to NUM_SLV slaves (GPIO, UART, timers).
Provides an address decoder, per-slave PSEL, wait-state handling, PSLVERR propagation and an optional stuck-slave timeout.
Sits between the system controller and the peripheral slaves, and replaces the fixed single-slave master/GPIO pairing.

---
 rtl/apb_bridge_pkg.sv | 24 ++
 rtl/apb_addr_decoder.sv | 30 +++
 rtl/apb_bridge_nslv.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the APB master bridge: FSM states, response codes
// and the slave-index width function.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } state_e;

  // Response classification; anything but RspOk is reported as rsp_err.
  typedef enum logic [1:0] {
    RspOk,
    RspSlvErr,
    RspDecErr,
    RspTimeout
  } rsp_code_e;

  // Width of the slave-index field, never less than one bit.
  function automatic int unsigned sel_w(input int unsigned num_slv);
    return (num_slv > 1) ? $clog2(num_slv) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave decoder: extracts the slave index from the byte address,
// produces the one-hot select and flags indices with no slave behind them.
module apb_addr_decoder
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned SLV_SEL_LSB = 28,
  parameter int unsigned SEL_W       = sel_w(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               decode_err_o
);

  localparam logic [SEL_W:0] NumSlvL = NUM_SLV[SEL_W:0];

  // Only the index field matters; the rest of the address is routed to PADDR elsewhere.
  logic unused_addr;
  assign unused_addr = ^addr_i;

  // Index extraction, range check and one-hot expansion.
  always_comb begin
    idx_o        = addr_i[SLV_SEL_LSB +: SEL_W];
    decode_err_o = ({1'b0, idx_o} >= NumSlvL);
    sel_o        = decode_err_o ? '0 : (NUM_SLV'(1) << idx_o);
  end

endmodule

// File: rtl/apb_bridge_nslv.sv
// APB3 master bridge: turns valid/ready commands into APB transfers to NUM_SLV
// slaves with address decode, wait states and PSLVERR propagation.
// Optional stuck-slave timeout enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_bridge_nslv
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned SLV_SEL_LSB = 28,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int unsigned SelW = sel_w(NUM_SLV);

  state_e              state_q, state_d;
  logic [SelW-1:0]     idx_q, idx_d;
  logic [NUM_SLV-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  rsp_code_e           rsp_code_q, rsp_code_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [SelW-1:0]     dec_idx;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_err;
  logic [DATA_W-1:0]   prdata_slv [NUM_SLV];
  logic                pready_sel, pslverr_sel;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

  apb_addr_decoder #(
    .ADDR_W      (ADDR_W),
    .NUM_SLV     (NUM_SLV),
    .SLV_SEL_LSB (SLV_SEL_LSB),
    .SEL_W       (SelW)
  ) u_dec (
    .addr_i       (cmd_addr),
    .idx_o        (dec_idx),
    .sel_o        (dec_sel),
    .decode_err_o (dec_err)
  );

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_prdata
    assign prdata_slv[i] = PRDATA[i*DATA_W +: DATA_W];
  end

  // Only the selected slave's handshake is observed.
  assign pready_sel  = PREADY[idx_q];
  assign pslverr_sel = PSLVERR[idx_q];

  // Bus and handshake outputs decoded from state; reset clears them without a clock.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    PSEL      = (state_q == StIdle) ? '0 : sel_q;
    PENABLE   = (state_q == StAccess);
    PADDR     = paddr_q;
    PWRITE    = pwrite_q;
    PWDATA    = pwdata_q;
    rsp_valid = rsp_valid_q;
    rsp_err   = (rsp_code_q != RspOk);
    rsp_rdata = rsp_rdata_q;
  end

  // Next-state logic for the transfer FSM, command capture and response.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (dec_err) begin
            // No bus activity; answer straight away.
            rsp_valid_d = 1'b1;
            rsp_code_d  = RspDecErr;
            rsp_rdata_d = '0;
          end else begin
            state_d  = StSetup;
            idx_d    = dec_idx;
            sel_d    = dec_sel;
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pwdata_d = cmd_write ? cmd_wdata : '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (pready_sel) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_code_d  = pslverr_sel ? RspSlvErr : RspOk;
          rsp_rdata_d = (!pwrite_q && !pslverr_sel) ? prdata_slv[idx_q] : '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          // This stalled cycle brings the count to the limit: abandon the transfer.
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RspTimeout;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      sel_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= RspOk;
      rsp_rdata_q <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule
